// File: rtl/mode_pkg.sv
// Shared types and constants for the stopwatch/timer mode arbiter.
// The keypad and display are shared between the two modes.
package mode_pkg;

  localparam logic MODE_SW = 1'b0;
  localparam logic MODE_TM = 1'b1;

  localparam int KEY_W  = 12;
  localparam int DISP_W = 24;

  typedef enum logic [1:0] {
    ST_STABLE   = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_BLANK    = 2'd3
  } state_e;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser for the mode switch plus the debounce run-length counter.
// count_en is high only while the controller sits in DEBOUNCE, so the count restarts on every entry.
module switch_debouncer
  import mode_pkg::*;
#(
  parameter int DEB_CYCLES = 1000,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_raw,
  input  logic cur_mode,
  input  logic count_en,
  output logic sw_s,
  output logic stable_diff
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sw_s        = sync2_q;
  assign stable_diff = count_en && (sync2_q != cur_mode) &&
                       (cnt_q == CNT_W'(DEB_CYCLES - 1));

  always_comb begin
    sync1_d = switch_raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    // Hold at the terminal value so the count can never wrap.
    if (count_en) begin
      cnt_d = stable_diff ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mode_arbiter.sv
// Sequenced owner of the shared keypad scanner and 7-segment display.
// A mode change goes debounce -> drain held key -> blank/flush -> commit.
module mode_arbiter
  import mode_pkg::*;
#(
  parameter int DEB_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch_raw,
  input  logic [KEY_W-1:0]  key_data,
  input  logic              rst_req_s,
  input  logic              rst_req_t,
  input  logic [DISP_W-1:0] sw_data,
  input  logic [DISP_W-1:0] tm_data,
  output logic              mode_sel,
  output logic [KEY_W-1:0]  key_to_sw,
  output logic [KEY_W-1:0]  key_to_tm,
  output logic              scan_rst,
  output logic [DISP_W-1:0] disp_data,
  output logic              busy,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic [KEY_W-1:0]  key_sw_q, key_sw_d;
  logic [KEY_W-1:0]  key_tm_q, key_tm_d;
  logic              scan_rst_q, scan_rst_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              busy_q, busy_d;
  logic              blank_next;
  logic              sw_s;
  logic              stable_diff;

  switch_debouncer #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb (
    .clk         (clk),
    .rst         (rst),
    .switch_raw  (switch_raw),
    .cur_mode    (mode_q),
    .count_en    (state_q == ST_DEBOUNCE),
    .sw_s        (sw_s),
    .stable_diff (stable_diff)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      ST_STABLE: begin
        if (sw_s != mode_q) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (sw_s == mode_q)   state_d = ST_STABLE;
        else if (stable_diff) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // No timeout: a held key must be released before routing can swap.
        if (sw_s == mode_q) begin
          state_d = ST_STABLE;
        end else if (key_data == '0) begin
          state_d     = ST_BLANK;
          blank_cnt_d = '0;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_STABLE;
          mode_d  = ~mode_q;
        end else begin
          blank_cnt_d = blank_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_STABLE;
    endcase

    // Output registers follow the next state so they line up with state_q.
    blank_next = (state_d == ST_BLANK);
    busy_d     = (state_d != ST_STABLE);
    key_sw_d   = (!blank_next && mode_d == MODE_SW) ? key_data : '0;
    key_tm_d   = (!blank_next && mode_d == MODE_TM) ? key_data : '0;
    scan_rst_d = blank_next | ((mode_d == MODE_SW) ? rst_req_s : rst_req_t);
    disp_d     = '0;
    if (!blank_next) disp_d = (mode_d == MODE_SW) ? sw_data : tm_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_STABLE;
      mode_q      <= MODE_SW;
      blank_cnt_q <= '0;
      key_sw_q    <= '0;
      key_tm_q    <= '0;
      scan_rst_q  <= 1'b0;
      disp_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      blank_cnt_q <= blank_cnt_d;
      key_sw_q    <= key_sw_d;
      key_tm_q    <= key_tm_d;
      scan_rst_q  <= scan_rst_d;
      disp_q      <= disp_d;
      busy_q      <= busy_d;
    end
  end

  assign mode_sel  = mode_q;
  assign key_to_sw = key_sw_q;
  assign key_to_tm = key_tm_q;
  assign scan_rst  = scan_rst_q;
  assign disp_data = disp_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
